// File: rtl/tpuv2.sv
// tpuv2: memory-mapped matrix-multiply accelerator (C += A x B over DIM x DIM tiles).
//
// A single DATAW-wide request bus reaches the A/B operand memories, the C
// accumulators, a control register that starts a multi-pass compute run, and a
// status register. An output-stationary systolic array computes the product.
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset
//   req       request valid; r_w/addr/dataIn sampled only when high
//   r_w       0 = read, 1 = write
//   addr      byte address; region = addr[11:8]
//   dataIn    write data
//   dataOut   registered read data, held until the next read
//   rvalid    one-cycle pulse, dataOut valid
//   busy      sequencer not idle
//   done_irq  sticky completion flag
module tpuv2 #(
   parameter int unsigned BITS_AB = 8,
   parameter int unsigned BITS_C  = 16,
   parameter int unsigned DIM     = 8,
   parameter int unsigned ADDRW   = 16,
   parameter int unsigned DATAW   = 64,
   parameter int unsigned PASSW   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic             r_w,
   input  logic [ADDRW-1:0] addr,
   input  logic [DATAW-1:0] dataIn,
   output logic [DATAW-1:0] dataOut,
   output logic             rvalid,
   output logic             busy,
   output logic             done_irq
);

   localparam int unsigned OFF     = $clog2(DATAW / 8);
   localparam int unsigned CW      = DIM * BITS_C / DATAW;   // C words per row
   localparam int unsigned EPW     = DATAW / BITS_C;         // C elements per word
   localparam int unsigned ROWW    = $clog2(DIM);
   localparam int unsigned WORDW   = $clog2(DIM * CW);
   localparam int unsigned SLW     = (CW > 1) ? $clog2(CW) : 1;
   localparam int unsigned CYC_MAX = 3 * DIM - 1;
   localparam int unsigned CYCW    = $clog2(3 * DIM);
   localparam int unsigned PW      = (2 * BITS_AB > BITS_C) ? 2 * BITS_AB : BITS_C;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [CYCW-1:0]   cyc_q, cyc_d;
   logic [PASSW-1:0]  pass_q, pass_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic [DATAW-1:0]  data_out_q;
   logic              rvalid_q;

   logic signed [BITS_AB-1:0] a_q      [DIM][DIM];
   logic signed [BITS_AB-1:0] b_q      [DIM][DIM];
   logic signed [BITS_AB-1:0] a_pipe_q [DIM][DIM];
   logic signed [BITS_AB-1:0] b_pipe_q [DIM][DIM];
   logic        [BITS_C-1:0]  c_q      [DIM][DIM];
   logic signed [BITS_AB-1:0] a_feed   [DIM];
   logic signed [BITS_AB-1:0] b_feed   [DIM];

   // ---------------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------------
   logic [3:0]       region;
   logic [ROWW-1:0]  ab_row;
   logic [WORDW-1:0] c_word;
   logic [ROWW-1:0]  c_row;
   logic [SLW-1:0]   c_slice;
   logic             wr, rd, busy_w, run;
   logic             a_wr, b_wr, c_wr, start, st_rd, bad_acc;
   logic             unused_addr;

   assign region  = addr[11:8];
   assign ab_row  = addr[OFF+ROWW-1:OFF];
   assign c_word  = addr[OFF+WORDW-1:OFF];
   // word = row * CW + slice with CW a power of two, so the row is the top bits
   assign c_row   = c_word[WORDW-1 -: ROWW];

   if (CW > 1) begin : g_slice
      assign c_slice = c_word[SLW-1:0];
   end else begin : g_no_slice
      assign c_slice = '0;
   end

   assign unused_addr = ^addr;

   assign busy_w  = (state_q != StIdle);
   assign run     = (state_q == StRun);
   assign wr      = req & r_w;
   assign rd      = req & ~r_w;
   assign a_wr    = wr & ~busy_w & (region == 4'd1);
   assign b_wr    = wr & ~busy_w & (region == 4'd2);
   assign c_wr    = wr & ~busy_w & (region == 4'd3);
   assign start   = wr & ~busy_w & (region == 4'd4);
   assign st_rd   = rd & (region == 4'd5);
   // Operand/control writes and C reads would race the running array
   assign bad_acc = busy_w & ((wr & (region >= 4'd1) & (region <= 4'd4)) |
                              (rd & (region == 4'd3)));

   // ---------------------------------------------------------------------------
   // Operand memories: A is row-addressed, B is a row shift register that fills
   // from the top so the first row written ends up as row 0.
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < DIM; i++) begin : g_mem_row
      for (genvar j = 0; j < DIM; j++) begin : g_mem_col
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_q[i][j] <= '0;
               b_q[i][j] <= '0;
            end else begin
               if (a_wr && ab_row == ROWW'(i)) begin
                  a_q[i][j] <= dataIn[j*BITS_AB +: BITS_AB];
               end
               if (b_wr) begin
                  if (i == DIM - 1) begin
                     b_q[i][j] <= dataIn[j*BITS_AB +: BITS_AB];
                  end else begin
                     b_q[i][j] <= b_q[(i+1)%DIM][j];
                  end
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Skewed feeders: at step t row i of A sends A[i][t-i], column j of B sends
   // B[t-j][j], so PE(i,j) meets A[i][k] and B[k][j] together at t = k+i+j.
   // ---------------------------------------------------------------------------
   logic [CYCW-1:0] t;
   assign t = CYCW'(CYC_MAX) - cyc_q;

   for (genvar i = 0; i < DIM; i++) begin : g_feed
      logic [CYCW:0] k;
      logic          k_ok;
      assign k         = {1'b0, t} - (CYCW+1)'(i);
      assign k_ok      = ~k[CYCW] && (k[CYCW-1:0] < CYCW'(DIM));
      assign a_feed[i] = k_ok ? a_q[i][k[ROWW-1:0]] : '0;
      assign b_feed[i] = k_ok ? b_q[k[ROWW-1:0]][i] : '0;
   end

   // ---------------------------------------------------------------------------
   // Systolic array; C accumulators double as the bus-visible C memory.
   // Pipelines drain to zero by the last step, so passes chain cleanly.
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < DIM; i++) begin : g_pe_row
      for (genvar j = 0; j < DIM; j++) begin : g_pe_col
         logic signed [BITS_AB-1:0] a_in, b_in;
         logic signed [PW-1:0]      prod;

         if (j == 0) begin : g_a_edge
            assign a_in = a_feed[i];
         end else begin : g_a_inner
            assign a_in = a_pipe_q[i][(j+DIM-1)%DIM];
         end
         if (i == 0) begin : g_b_edge
            assign b_in = b_feed[j];
         end else begin : g_b_inner
            assign b_in = b_pipe_q[(i+DIM-1)%DIM][j];
         end

         assign prod = PW'(a_in) * PW'(b_in);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_pipe_q[i][j] <= '0;
               b_pipe_q[i][j] <= '0;
               c_q[i][j]      <= '0;
            end else if (run) begin
               a_pipe_q[i][j] <= a_in;
               b_pipe_q[i][j] <= b_in;
               c_q[i][j]      <= c_q[i][j] + prod[BITS_C-1:0];
            end else if (c_wr && c_row == ROWW'(i) && c_slice == SLW'(j / EPW)) begin
               // Other slices of the row are left alone: read-modify-write
               c_q[i][j] <= dataIn[(j % EPW)*BITS_C +: BITS_C];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // C read path
   // ---------------------------------------------------------------------------
   logic [DIM*BITS_C-1:0] c_row_flat;
   logic [DATAW-1:0]      c_row_words [CW];
   logic [DATAW-1:0]      c_rd_word;

   for (genvar j = 0; j < DIM; j++) begin : g_row_flat
      assign c_row_flat[j*BITS_C +: BITS_C] = c_q[c_row][j];
   end
   for (genvar s = 0; s < CW; s++) begin : g_row_words
      assign c_row_words[s] = c_row_flat[s*DATAW +: DATAW];
   end
   assign c_rd_word = c_row_words[c_slice];

   // ---------------------------------------------------------------------------
   // Sequencer
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      pass_d  = pass_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               cyc_d   = CYCW'(CYC_MAX);
               pass_d  = (dataIn[PASSW-1:0] == '0) ? PASSW'(1) : dataIn[PASSW-1:0];
            end
         end
         StRun: begin
            if (cyc_q == '0) begin
               if (pass_q > PASSW'(1)) begin
                  pass_d = pass_q - PASSW'(1);
                  cyc_d  = CYCW'(CYC_MAX);
               end else begin
                  state_d = StDone;
               end
            end else begin
               cyc_d = cyc_q - CYCW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Setting wins over clearing so a status read during DONE keeps the flag
   always_comb begin
      done_d = done_q;
      err_d  = err_q;
      if (st_rd || start) begin
         done_d = 1'b0;
         err_d  = 1'b0;
      end
      if (state_q == StDone) done_d = 1'b1;
      if (bad_acc)           err_d  = 1'b1;
   end

   logic [PASSW+2:0] status;
   logic [DATAW-1:0] rdata;

   assign status = {err_q, done_q | (state_q == StDone), busy_w, pass_q};

   always_comb begin
      rdata = '0;
      if (region == 4'd3 && !busy_w) begin
         rdata = c_rd_word;
      end else if (region == 4'd5) begin
         rdata = DATAW'(status);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cyc_q      <= '0;
         pass_q     <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         data_out_q <= '0;
         rvalid_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         pass_q   <= pass_d;
         err_q    <= err_d;
         done_q   <= done_d;
         rvalid_q <= rd;
         if (rd) data_out_q <= rdata;
      end
   end

   assign dataOut  = data_out_q;
   assign rvalid   = rvalid_q;
   assign busy     = busy_w;
   assign done_irq = done_q;

endmodule

// File: tb/tb_tpuv2.sv
// tb_tpuv2: scoreboard bench for tpuv2 (DIM=8, 8-bit A/B, 16-bit C, 64-bit bus).
// Reads push {expected data, mask, due cycle} into a queue; a monitor pops and
// compares on every rvalid pulse.
module tb_tpuv2;

   localparam int DIM = 8;
   localparam int CYC = 3 * DIM;
   localparam logic [15:0] A_BASE = 16'h0100;
   localparam logic [15:0] B_BASE = 16'h0200;
   localparam logic [15:0] C_BASE = 16'h0300;
   localparam logic [15:0] CTRL   = 16'h0400;
   localparam logic [15:0] STAT   = 16'h0500;
   localparam logic [63:0] FLAGS  = ~64'hFF;   // everything except pass_remaining
   localparam logic [63:0] ALL    = ~64'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        r_w = 1'b0;
   logic [15:0] addr = '0;
   logic [63:0] dataIn = '0;
   logic [63:0] dataOut;
   logic        rvalid, busy, done_irq;

   tpuv2 #(
      .BITS_AB (8),
      .BITS_C  (16),
      .DIM     (DIM),
      .ADDRW   (16),
      .DATAW   (64),
      .PASSW   (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .r_w      (r_w),
      .addr     (addr),
      .dataIn   (dataIn),
      .dataOut  (dataOut),
      .rvalid   (rvalid),
      .busy     (busy),
      .done_irq (done_irq)
   );

   always #5 clk = ~clk;

   int cnt = 0;
   always @(posedge clk) cnt <= cnt + 1;

   typedef struct {
      logic [63:0] data;
      logic [63:0] mask;
      int          due;
      int          tag;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   tag_n  = 0;

   // Reference model of operand and accumulator contents
   int          am [DIM][DIM];
   int          bm [DIM][DIM];
   logic [15:0] cm [DIM][DIM];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, want);
      end
   endtask

   always @(negedge clk) begin
      if (rvalid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rvalid: unexpected pulse at cycle %0d", cnt);
         end else begin
            mon_e = exp_q.pop_front();
            check($sformatf("read%0d data", mon_e.tag), dataOut & mon_e.mask,
                  mon_e.data & mon_e.mask);
            check($sformatf("read%0d latency", mon_e.tag), 64'(cnt), 64'(mon_e.due));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      req = 1'b0;
      r_w = 1'b0;
      addr = '0;
      dataIn = '0;
   endtask

   task automatic issue_wr(input logic [15:0] a, input logic [63:0] d);
      req = 1'b1;
      r_w = 1'b1;
      addr = a;
      dataIn = d;
   endtask

   // Data is due one cycle after the request cycle
   task automatic issue_rd(input logic [15:0] a, input logic [63:0] d, input logic [63:0] m);
      exp_t e;
      req = 1'b1;
      r_w = 1'b0;
      addr = a;
      e.data = d;
      e.mask = m;
      e.due = cnt + 1;
      e.tag = tag_n++;
      exp_q.push_back(e);
   endtask

   task automatic wr(input logic [15:0] a, input logic [63:0] d);
      step();
      issue_wr(a, d);
   endtask

   task automatic rd(input logic [15:0] a, input logic [63:0] d, input logic [63:0] m);
      step();
      issue_rd(a, d, m);
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   function automatic logic [63:0] status_val(input bit err, input bit done, input bit bsy,
                                              input int pass);
      logic [63:0] v;
      v = '0;
      v[7:0] = 8'(pass);
      v[8] = bsy;
      v[9] = done;
      v[10] = err;
      return v;
   endfunction

   function automatic logic [63:0] cword(input int r, input int s);
      logic [63:0] v;
      for (int e = 0; e < 4; e++) v[e*16 +: 16] = cm[r][s*4+e];
      return v;
   endfunction

   task automatic write_a(input int r, input logic [63:0] d);
      wr(A_BASE + 16'(r * 8), d);
      for (int k = 0; k < DIM; k++) am[r][k] = int'($signed(d[k*8 +: 8]));
   endtask

   task automatic write_b(input logic [63:0] d);
      wr(B_BASE, d);
      for (int i = 0; i < DIM - 1; i++) begin
         for (int j = 0; j < DIM; j++) bm[i][j] = bm[i+1][j];
      end
      for (int j = 0; j < DIM; j++) bm[DIM-1][j] = int'($signed(d[j*8 +: 8]));
   endtask

   task automatic write_c(input int w, input logic [63:0] d);
      wr(C_BASE + 16'(w * 8), d);
      for (int e = 0; e < 4; e++) cm[w/2][(w%2)*4+e] = d[e*16 +: 16];
   endtask

   task automatic accumulate(input int p);
      int pe, sum;
      pe = (p == 0) ? 1 : p;
      for (int r = 0; r < DIM; r++) begin
         for (int j = 0; j < DIM; j++) begin
            sum = 0;
            for (int k = 0; k < DIM; k++) sum += am[r][k] * bm[k][j];
            cm[r][j] = cm[r][j] + 16'(pe * sum);
         end
      end
   endtask

   task automatic clear_c();
      for (int w = 0; w < 2 * DIM; w++) write_c(w, 64'h0);
   endtask

   task automatic read_c_all();
      for (int w = 0; w < 2 * DIM; w++) rd(C_BASE + 16'(w * 8), cword(w / 2, w % 2), ALL);
      idle(2);
   endtask

   // mode 1: status read in pass 2; mode 2: A write and C read while busy
   task automatic run_passes(input int p, input int mode, output int n);
      wr(CTRL, 64'(p));
      n = 0;
      for (int g = 0; g < 1000; g++) begin
         step();
         if (busy !== 1'b1) break;
         n++;
         if (mode == 1 && n == 30) issue_rd(STAT, status_val(0, 0, 1, 2), ALL);
         if (mode == 2 && n == 5)  issue_wr(A_BASE, 64'h7f7f_7f7f_7f7f_7f7f);
         if (mode == 2 && n == 8)  issue_rd(C_BASE + 16'd8, 64'h0, ALL);
      end
      accumulate(p);
      idle(2);
   endtask

   int n;

   initial begin
      for (int i = 0; i < DIM; i++) begin
         for (int j = 0; j < DIM; j++) begin
            am[i][j] = 0;
            bm[i][j] = 0;
            cm[i][j] = '0;
         end
      end

      idle(3);
      check("reset dataOut", dataOut, 64'h0);
      check("reset rvalid", 64'(rvalid), 64'h0);
      check("reset busy", 64'(busy), 64'h0);
      check("reset done_irq", 64'(done_irq), 64'h0);
      step();
      rst = 1'b0;
      idle(2);

      // A = identity, B row i = all (i+1), C = 0, one pass: C row r = r+1
      for (int r = 0; r < DIM; r++) write_a(r, 64'h1 << (8 * r));
      for (int i = 0; i < DIM; i++) write_b({8{8'(i + 1)}});
      clear_c();
      run_passes(1, 0, n);
      // RUN cycles plus the single DONE cycle
      check("busy cycles passes=1", 64'(n), 64'(CYC + 1));
      read_c_all();
      rd(STAT, status_val(0, 1, 0, 0), FLAGS);

      // Three accumulating passes: C row r = 3*(r+1)
      clear_c();
      run_passes(3, 1, n);
      check("busy cycles passes=3", 64'(n), 64'(3 * CYC + 1));
      read_c_all();
      rd(STAT, status_val(0, 1, 0, 0), FLAGS);
      rd(STAT, status_val(0, 0, 0, 0), FLAGS);
      check("done_irq cleared", 64'(done_irq), 64'h0);

      // Slice write on row 2; slice 0 keeps 3*3 in every element
      write_c(5, 64'h0004_0003_0002_0001);
      rd(C_BASE + 16'd32, 64'h0009_0009_0009_0009, ALL);
      rd(C_BASE + 16'd40, 64'h0004_0003_0002_0001, ALL);
      idle(2);

      // passes=0 runs one pass; busy-time A write and C read are rejected
      run_passes(0, 2, n);
      check("busy cycles passes=0", 64'(n), 64'(CYC + 1));
      check("done_irq set", 64'(done_irq), 64'h1);
      rd(STAT, status_val(1, 1, 0, 0), FLAGS);
      read_c_all();
      rd(C_BASE + 16'd40, 64'h0007_0006_0005_0004, ALL);
      idle(2);

      // Reset for one cycle in the middle of a run
      wr(CTRL, 64'd2);
      idle(10);
      check("busy before reset", 64'(busy), 64'h1);
      step();
      rst = 1'b1;
      #1;
      check("busy after reset", 64'(busy), 64'h0);
      check("done_irq after reset", 64'(done_irq), 64'h0);
      step();
      rst = 1'b0;
      for (int i = 0; i < DIM; i++) begin
         for (int j = 0; j < DIM; j++) begin
            am[i][j] = 0;
            bm[i][j] = 0;
            cm[i][j] = '0;
         end
      end
      idle(2);
      read_c_all();
      rd(STAT, status_val(0, 0, 0, 0), ALL);
      idle(4);

      check("pending reads", 64'(exp_q.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
